mii_rx_packer: RTL and testbench

- Generalised receive-side symbol packer for the Ethernet PHY interface.
- Accepts IN_W-bit PHY symbols (RMII 2, MII 4, GMII 8), optionally hunts and strips preamble/SFD, and packs payload LSB-first into OUT_W-bit words.
- Adds frame delimiting (sof/eof), a byte-keep mask for the last word, and error flagging.
- Sits between the PHY pins and the UDP/IP header parser.

---
 rtl/mii_rx_packer.sv | 186 ++++++++++++++++++
 tb/tb_mii_rx_packer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mii_rx_packer.sv
// Receive-side PHY symbol packer: optional preamble/SFD hunt, LSB-first packing
// of IN_W-bit symbols into OUT_W-bit words with sof/eof/keep/err framing.
module mii_rx_packer #(
    parameter int unsigned IN_W       = 4,
    parameter int unsigned OUT_W      = 8,
    parameter int unsigned SFD_DETECT = 1
) (
    input  logic                 rx_clk,
    input  logic                 rst_n,
    input  logic [IN_W-1:0]      rx_data,
    input  logic                 rx_valid,
    input  logic                 rx_er,
    output logic [OUT_W-1:0]     out_data,
    output logic                 out_valid,
    output logic [OUT_W/8-1:0]   out_keep,
    output logic                 out_sof,
    output logic                 out_eof,
    output logic                 out_err
);
    localparam int unsigned RATIO  = OUT_W / IN_W;
    localparam int unsigned SPB    = 8 / IN_W;
    localparam int unsigned KEEP_W = OUT_W / 8;
    localparam int unsigned PH_W   = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(RATIO - 1);
    localparam logic [7:0]      SFD     = 8'hD5;

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, HUNT, DATA} state_t;

    state_t              state, state_nxt;
    logic [PH_W-1:0]     phase, phase_nxt;
    logic [OUT_W-1:0]    acc, acc_nxt;
    logic [OUT_W-1:0]    pend, pend_nxt;
    logic                pend_v, pend_v_nxt;
    logic                first_q, first_nxt;
    logic                err_q, err_nxt;
    logic [7:0]          sr, sr_nxt;
    logic [7:0]          sr_shift;
    logic                cap;
    logic [OUT_W-1:0]    o_data;
    logic [KEEP_W-1:0]   o_keep;
    logic                o_valid, o_sof, o_eof, o_err;

    // New symbol enters at the top; for IN_W=8 this is a plain load
    assign sr_shift = 8'({rx_data, sr} >> IN_W);

    always_ff @(posedge rx_clk) begin
        if (!rst_n) begin
            state     <= WAIT_IDLE;
            phase     <= '0;
            acc       <= '0;
            pend      <= '0;
            pend_v    <= 1'b0;
            first_q   <= 1'b0;
            err_q     <= 1'b0;
            sr        <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_keep  <= '0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            phase     <= phase_nxt;
            acc       <= acc_nxt;
            pend      <= pend_nxt;
            pend_v    <= pend_v_nxt;
            first_q   <= first_nxt;
            err_q     <= err_nxt;
            sr        <= sr_nxt;
            out_data  <= o_data;
            out_valid <= o_valid;
            out_keep  <= o_keep;
            out_sof   <= o_sof;
            out_eof   <= o_eof;
            out_err   <= o_err;
        end
    end

    always_comb begin
        state_nxt  = state;
        phase_nxt  = phase;
        acc_nxt    = acc;
        pend_nxt   = pend;
        pend_v_nxt = pend_v;
        first_nxt  = first_q;
        err_nxt    = err_q;
        sr_nxt     = sr;
        cap        = 1'b0;
        o_data     = '0;
        o_valid    = 1'b0;
        o_keep     = '0;
        o_sof      = 1'b0;
        o_eof      = 1'b0;
        o_err      = 1'b0;

        case (state)
            WAIT_IDLE: begin
                if (!rx_valid) state_nxt = IDLE;
            end
            IDLE: begin
                phase_nxt  = '0;
                pend_v_nxt = 1'b0;
                err_nxt    = 1'b0;
                sr_nxt     = '0;
                if (rx_valid) begin
                    first_nxt = 1'b1;
                    if (SFD_DETECT != 0) begin
                        state_nxt = HUNT;
                        sr_nxt    = 8'({rx_data, 8'h00} >> IN_W);
                    end else begin
                        state_nxt = DATA;
                        cap       = 1'b1;
                    end
                end
            end
            HUNT: begin
                if (!rx_valid) begin
                    state_nxt = IDLE;
                end else if (rx_er) begin
                    state_nxt = WAIT_IDLE;
                end else begin
                    sr_nxt = sr_shift;
                    if (sr_shift == SFD) begin
                        state_nxt = DATA;
                        phase_nxt = '0;
                    end
                end
            end
            DATA: begin
                if (rx_valid) begin
                    cap = 1'b1;
                end else begin
                    state_nxt  = IDLE;
                    phase_nxt  = '0;
                    pend_v_nxt = 1'b0;
                    err_nxt    = 1'b0;
                    if (phase == '0 && pend_v) begin
                        o_valid = 1'b1;
                        o_data  = pend;
                        o_keep  = '1;
                        o_sof   = first_q;
                        o_eof   = 1'b1;
                        o_err   = err_q;
                    end else if (phase != '0) begin
                        // Only whole bytes survive; a dribble nibble flags an error
                        for (int b = 0; b < int'(KEEP_W); b++) begin
                            if (32'(phase) >= 32'((b + 1) * SPB)) begin
                                o_keep[b]        = 1'b1;
                                o_data[8*b +: 8] = acc[8*b +: 8];
                            end
                        end
                        o_valid = 1'b1;
                        o_sof   = first_q;
                        o_eof   = 1'b1;
                        o_err   = err_q | ((32'(phase) % SPB) != 0);
                    end
                end
            end
            default: state_nxt = WAIT_IDLE;
        endcase

        // Payload capture, shared by IDLE (no SFD hunt) and DATA
        if (cap) begin
            for (int i = 0; i < int'(RATIO); i++) begin
                if (phase == PH_W'(i)) acc_nxt[i*IN_W +: IN_W] = rx_data;
            end
            if (rx_er) err_nxt = 1'b1;
            if (pend_v) begin
                o_valid    = 1'b1;
                o_data     = pend;
                o_keep     = '1;
                o_sof      = first_q;
                first_nxt  = 1'b0;
                pend_v_nxt = 1'b0;
            end
            if (phase == PH_LAST) begin
                pend_nxt   = acc_nxt;
                pend_v_nxt = 1'b1;
                phase_nxt  = '0;
            end else begin
                phase_nxt = phase + PH_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_mii_rx_packer.sv
// Scoreboard bench for mii_rx_packer: four configurations share one clock,
// stimulus pushes expected words, a negedge monitor pops and compares.
module tb_mii_rx_packer;
    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        sof;
        logic        eof;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [3:0]  d0, d1;
    logic [1:0]  d2;
    logic [7:0]  d3;
    logic        vv [4];
    logic        ee [4];
    logic [15:0] od0;
    logic [7:0]  od1;
    logic [31:0] od2;
    logic [7:0]  od3;
    logic [1:0]  ok0;
    logic [0:0]  ok1;
    logic [3:0]  ok2;
    logic [0:0]  ok3;
    logic        ov [4];
    logic        os [4];
    logic        oe [4];
    logic        oerr [4];

    exp_t q0[$], q1[$], q2[$], q3[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    mii_rx_packer #(.IN_W(4), .OUT_W(16), .SFD_DETECT(1)) u0 (
        .rx_clk(clk), .rst_n(rst_n), .rx_data(d0), .rx_valid(vv[0]), .rx_er(ee[0]),
        .out_data(od0), .out_valid(ov[0]), .out_keep(ok0), .out_sof(os[0]),
        .out_eof(oe[0]), .out_err(oerr[0]));
    mii_rx_packer #(.IN_W(4), .OUT_W(8), .SFD_DETECT(0)) u1 (
        .rx_clk(clk), .rst_n(rst_n), .rx_data(d1), .rx_valid(vv[1]), .rx_er(ee[1]),
        .out_data(od1), .out_valid(ov[1]), .out_keep(ok1), .out_sof(os[1]),
        .out_eof(oe[1]), .out_err(oerr[1]));
    mii_rx_packer #(.IN_W(2), .OUT_W(32), .SFD_DETECT(1)) u2 (
        .rx_clk(clk), .rst_n(rst_n), .rx_data(d2), .rx_valid(vv[2]), .rx_er(ee[2]),
        .out_data(od2), .out_valid(ov[2]), .out_keep(ok2), .out_sof(os[2]),
        .out_eof(oe[2]), .out_err(oerr[2]));
    mii_rx_packer #(.IN_W(8), .OUT_W(8), .SFD_DETECT(0)) u3 (
        .rx_clk(clk), .rst_n(rst_n), .rx_data(d3), .rx_valid(vv[3]), .rx_er(ee[3]),
        .out_data(od3), .out_valid(ov[3]), .out_keep(ok3), .out_sof(os[3]),
        .out_eof(oe[3]), .out_err(oerr[3]));

    function automatic exp_t get_act(input int k);
        exp_t a;
        case (k)
            0:       a = '{64'(od0), 8'(ok0), os[0], oe[0], oerr[0] & oe[0]};
            1:       a = '{64'(od1), 8'(ok1), os[1], oe[1], oerr[1] & oe[1]};
            2:       a = '{64'(od2), 8'(ok2), os[2], oe[2], oerr[2] & oe[2]};
            default: a = '{64'(od3), 8'(ok3), os[3], oe[3], oerr[3] & oe[3]};
        endcase
        return a;
    endfunction

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            2:       return q2.size();
            default: return q3.size();
        endcase
    endfunction

    task automatic push(input int k, input logic [63:0] data, input logic [7:0] keep,
                        input logic sof, input logic eof, input logic err);
        exp_t e;
        e = '{data, keep, sof, eof, err};
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            2:       q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    task automatic check(input int k, input exp_t act);
        exp_t e;
        bit   have;
        have = 1'b0;
        e    = '0;
        if (qsize(k) > 0) begin
            have = 1'b1;
            case (k)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                2:       e = q2.pop_front();
                default: e = q3.pop_front();
            endcase
        end
        n_tests++;
        if (!have) begin
            n_fail++;
            $display("FAIL unexpected_word dut%0d: got data=%h keep=%b sof=%b eof=%b err=%b, required no output",
                     k, act.data, act.keep, act.sof, act.eof, act.err);
        end else if (act !== e) begin
            n_fail++;
            $display("FAIL word dut%0d: got data=%h keep=%b sof=%b eof=%b err=%b, required data=%h keep=%b sof=%b eof=%b err=%b",
                     k, act.data, act.keep, act.sof, act.eof, act.err,
                     e.data, e.keep, e.sof, e.eof, e.err);
        end
    endtask

    // Monitor: decoupled from stimulus, samples on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                if (ov[k]) check(k, get_act(k));
            end
        end
    end

    function automatic int width(input int k);
        return (k == 2) ? 2 : (k == 3) ? 8 : 4;
    endfunction

    task automatic sym(input int k, input logic [7:0] s, input logic er);
        @(negedge clk);
        case (k)
            0:       d0 = s[3:0];
            1:       d1 = s[3:0];
            2:       d2 = s[1:0];
            default: d3 = s;
        endcase
        vv[k] = 1'b1;
        ee[k] = er;
    endtask

    task automatic send_byte(input int k, input logic [7:0] b, input int er_sym);
        logic [7:0] t;
        int         w;
        w = width(k);
        for (int i = 0; i < 8 / w; i++) begin
            t = b >> (i * w);
            sym(k, t, i == er_sym);
        end
    endtask

    task automatic pre(input int k, input int er_byte);
        for (int i = 0; i < 7; i++) send_byte(k, 8'h55, (i == er_byte) ? 0 : -1);
        send_byte(k, 8'hD5, -1);
    endtask

    task automatic idle(input int k, input int n);
        repeat (n) begin
            @(negedge clk);
            vv[k] = 1'b0;
            ee[k] = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        for (int k = 0; k < 4; k++) begin
            vv[k] = 1'b0;
            ee[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (get_act(k) !== '0 || ov[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs dut%0d: got valid=%b word=%h, required all zero",
                         k, ov[k], get_act(k));
            end
        end
        rst_n = 1'b1;
        idle(0, 2);

        // Preamble + 3 payload bytes: one full word, then a one-byte tail
        push(0, 64'h2211, 8'b11, 1'b1, 1'b0, 1'b0);
        push(0, 64'h0033, 8'b01, 1'b0, 1'b1, 1'b0);
        pre(0, -1);
        send_byte(0, 8'h11, -1); send_byte(0, 8'h22, -1); send_byte(0, 8'h33, -1);
        idle(0, 1);
        // Exactly one word, back-to-back after a single idle cycle
        push(0, 64'h2211, 8'b11, 1'b1, 1'b1, 1'b0);
        pre(0, -1);
        send_byte(0, 8'h11, -1); send_byte(0, 8'h22, -1);
        idle(0, 1);
        // rx_er during the hunt drops the whole frame
        pre(0, 2);
        send_byte(0, 8'h99, -1); send_byte(0, 8'h88, -1);
        idle(0, 1);
        push(0, 64'h5544, 8'b11, 1'b1, 1'b1, 1'b0);
        pre(0, -1);
        send_byte(0, 8'h44, -1); send_byte(0, 8'h55, -1);
        idle(0, 2);

        // Reset mid-frame, released while rx_valid is still high
        push(0, 64'h2211, 8'b11, 1'b1, 1'b0, 1'b0);
        pre(0, -1);
        send_byte(0, 8'h11, -1); send_byte(0, 8'h22, -1); send_byte(0, 8'h33, -1);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk); rst_n = 1'b1;
        pre(0, -1);
        send_byte(0, 8'hAA, -1); send_byte(0, 8'hBB, -1);
        idle(0, 1);
        push(0, 64'h7766, 8'b11, 1'b1, 1'b1, 1'b0);
        pre(0, -1);
        send_byte(0, 8'h66, -1); send_byte(0, 8'h77, -1);
        idle(0, 2);

        // Odd nibble count: dribble error on an empty tail word
        push(1, 64'h11, 8'b1, 1'b1, 1'b0, 1'b0);
        push(1, 64'h00, 8'b0, 1'b0, 1'b1, 1'b1);
        sym(1, 8'h1, 1'b0); sym(1, 8'h1, 1'b0); sym(1, 8'h2, 1'b0);
        idle(1, 1);
        push(1, 64'h34, 8'b1, 1'b1, 1'b0, 1'b0);
        push(1, 64'h56, 8'b1, 1'b0, 1'b1, 1'b0);
        send_byte(1, 8'h34, -1); send_byte(1, 8'h56, -1);
        idle(1, 2);

        // RMII into 32 bits with rx_er on one payload symbol, then a clean frame
        push(2, 64'hEFBEADDE, 8'b1111, 1'b1, 1'b1, 1'b1);
        pre(2, -1);
        send_byte(2, 8'hDE, -1); send_byte(2, 8'hAD, 1);
        send_byte(2, 8'hBE, -1); send_byte(2, 8'hEF, -1);
        idle(2, 1);
        push(2, 64'h04030201, 8'b1111, 1'b1, 1'b1, 1'b0);
        pre(2, -1);
        send_byte(2, 8'h01, -1); send_byte(2, 8'h02, -1);
        send_byte(2, 8'h03, -1); send_byte(2, 8'h04, -1);
        idle(2, 2);

        // Byte-wide pass-through framing
        push(3, 64'hA1, 8'b1, 1'b1, 1'b0, 1'b0);
        push(3, 64'hB2, 8'b1, 1'b0, 1'b1, 1'b0);
        push(3, 64'hC3, 8'b1, 1'b1, 1'b1, 1'b0);
        sym(3, 8'hA1, 1'b0); sym(3, 8'hB2, 1'b0);
        idle(3, 1);
        sym(3, 8'hC3, 1'b0);
        idle(3, 5);

        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (qsize(k) != 0) begin
                n_fail++;
                $display("FAIL missing_words dut%0d: got %0d words outstanding, required 0", k, qsize(k));
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
